// File: rtl/ram_block_packer.sv
// Packs a valid/ready stream of IN_WIDTH words into D_WIDTH RAM blocks, little-endian,
// and issues one registered write per block while tracking slot occupancy.
module ram_block_packer #(
  parameter int D_WIDTH  = 128,
  parameter int IN_WIDTH = 32,
  parameter int A_WIDTH  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_last,
  output logic                w_en,
  output logic [A_WIDTH-1:0]  w_addr,
  output logic [D_WIDTH-1:0]  w_data,
  output logic                w_last,
  input  logic                blk_rel,
  output logic [A_WIDTH:0]    fill,
  output logic                full,
  output logic                empty,
  output logic                err
);

  localparam int LANES   = D_WIDTH / IN_WIDTH;
  localparam int L_WIDTH = $clog2(LANES);
  localparam int DEPTH   = 2 ** A_WIDTH;

  localparam logic [A_WIDTH:0]    FILL_MAX = (A_WIDTH + 1)'(DEPTH);
  localparam logic [L_WIDTH-1:0]  LANE_MAX = L_WIDTH'(LANES - 1);

  logic [L_WIDTH-1:0] lane_q, lane_d;
  logic [D_WIDTH-1:0] asm_q, asm_d;
  logic               w_en_q, w_en_d;
  logic [A_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [D_WIDTH-1:0] w_data_q, w_data_d;
  logic               w_last_q, w_last_d;
  logic [A_WIDTH:0]   fill_q, fill_d;
  logic               err_q, err_d;

  logic               accept;
  logic               commit;
  logic               release_ok;
  logic [D_WIDTH-1:0] packed_blk;

  assign full     = (fill_q == FILL_MAX);
  assign empty    = (fill_q == '0);
  assign in_ready = ~rst & ~full;

  assign accept     = in_valid & in_ready;
  assign commit     = accept & ((lane_q == LANE_MAX) | in_last);
  assign release_ok = blk_rel & ~empty;

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    packed_blk = asm_q;
    packed_blk[lane_q*IN_WIDTH +: IN_WIDTH] = in_data;

    lane_d   = lane_q;
    asm_d    = asm_q;
    w_en_d   = commit;
    w_data_d = w_data_q;
    w_last_d = commit & in_last;
    w_addr_d = w_addr_q + A_WIDTH'(w_en_q);
    fill_d   = fill_q;
    err_d    = err_q | (blk_rel & empty);

    // The assembly register is cleared on commit, so lanes above a short
    // final word are already zero in packed_blk.
    if (accept) begin
      if (commit) begin
        lane_d   = '0;
        asm_d    = '0;
        w_data_d = packed_blk;
      end else begin
        lane_d = lane_q + 1'b1;
        asm_d  = packed_blk;
      end
    end

    case ({commit, release_ok})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q   <= '0;
      asm_q    <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_last_q <= 1'b0;
      fill_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      lane_q   <= lane_d;
      asm_q    <= asm_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      w_last_q <= w_last_d;
      fill_q   <= fill_d;
      err_q    <= err_d;
    end
  end

  assign w_en   = w_en_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;
  assign w_last = w_last_q;
  assign fill   = fill_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ram_block_packer.sv
// Scoreboard bench for ram_block_packer: a cycle model queues expected blocks on
// each accepted completing word and the monitor pops them on every w_en pulse.
module tb_ram_block_packer;

  localparam int D_WIDTH  = 128;
  localparam int IN_WIDTH = 32;
  localparam int A_WIDTH  = 3;
  localparam int DEPTH    = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [IN_WIDTH-1:0] in_data = '0;
  logic                in_last = 1'b0;
  logic                w_en;
  logic [A_WIDTH-1:0]  w_addr;
  logic [D_WIDTH-1:0]  w_data;
  logic                w_last;
  logic                blk_rel = 1'b0;
  logic [A_WIDTH:0]    fill;
  logic                full;
  logic                empty;
  logic                err;

  ram_block_packer #(.D_WIDTH(D_WIDTH), .IN_WIDTH(IN_WIDTH), .A_WIDTH(A_WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .w_last   (w_last),
    .blk_rel  (blk_rel),
    .fill     (fill),
    .full     (full),
    .empty    (empty),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [A_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0] data;
    logic               last;
  } blk_t;

  blk_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  int                 m_fill = 0;
  int                 m_lane = 0;
  logic [A_WIDTH-1:0] m_addr = '0;
  logic [D_WIDTH-1:0] m_asm  = '0;
  logic               m_err  = 1'b0;
  int                 max_fill = 0;
  bit                 rand_done = 1'b0;

  task automatic check(input string tag, input logic [D_WIDTH-1:0] got,
                       input logic [D_WIDTH-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: sees the same pre-edge inputs as the DUT.
  always @(posedge clk) begin : model
    bit commit;
    bit dec;
    if (!rst) begin
      commit = 1'b0;
      dec    = 1'b0;
      if (in_valid && in_ready) begin
        m_asm[m_lane*IN_WIDTH +: IN_WIDTH] = in_data;
        if (m_lane == 3 || in_last) begin
          sb_q.push_back('{addr: m_addr, data: m_asm, last: in_last});
          m_addr = m_addr + 1'b1;
          m_asm  = '0;
          m_lane = 0;
          commit = 1'b1;
        end else begin
          m_lane++;
        end
      end
      if (blk_rel) begin
        if (m_fill == 0) m_err = 1'b1;
        else dec = 1'b1;
      end
      m_fill = m_fill + int'(commit) - int'(dec);
    end
  end

  always @(negedge clk) begin : monitor
    blk_t e;
    if (!rst) begin
      if (w_en) begin
        if (sb_q.size() == 0) begin
          check("unexpected_wen", D_WIDTH'(1), D_WIDTH'(0));
        end else begin
          e = sb_q.pop_front();
          check("blk_addr", D_WIDTH'(w_addr), D_WIDTH'(e.addr));
          check("blk_data", w_data, e.data);
          check("blk_last", D_WIDTH'(w_last), D_WIDTH'(e.last));
        end
      end
      check("fill",     D_WIDTH'(fill),     D_WIDTH'(m_fill));
      check("full",     D_WIDTH'(full),     D_WIDTH'(m_fill == DEPTH));
      check("empty",    D_WIDTH'(empty),    D_WIDTH'(m_fill == 0));
      check("in_ready", D_WIDTH'(in_ready), D_WIDTH'(m_fill != DEPTH));
      check("err",      D_WIDTH'(err),      D_WIDTH'(m_err));
      if (m_fill > max_fill) max_fill = m_fill;
    end
  end

  // Called at posedge+1; asserts rst between edges and checks the async clear.
  task automatic apply_reset;
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    blk_rel  = 1'b0;
    sb_q.delete();
    m_fill = 0;
    m_lane = 0;
    m_addr = '0;
    m_asm  = '0;
    m_err  = 1'b0;
    #1;
    check("rst_in_ready", D_WIDTH'(in_ready), D_WIDTH'(0));
    check("rst_w_en",     D_WIDTH'(w_en),     D_WIDTH'(0));
    check("rst_w_addr",   D_WIDTH'(w_addr),   D_WIDTH'(0));
    check("rst_w_data",   w_data,             D_WIDTH'(0));
    check("rst_w_last",   D_WIDTH'(w_last),   D_WIDTH'(0));
    check("rst_fill",     D_WIDTH'(fill),     D_WIDTH'(0));
    check("rst_full",     D_WIDTH'(full),     D_WIDTH'(0));
    check("rst_empty",    D_WIDTH'(empty),    D_WIDTH'(1));
    check("rst_err",      D_WIDTH'(err),      D_WIDTH'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Presents one word and returns at posedge+1 of the edge that accepted it.
  task automatic send_word(input logic [IN_WIDTH-1:0] d, input logic last);
    int budget = 500;
    bit taken  = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!taken && budget > 0) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
      budget--;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!taken) check("accept_timeout", D_WIDTH'(0), D_WIDTH'(1));
  endtask

  task automatic pulse_rel;
    blk_rel = 1'b1;
    @(posedge clk);
    #1;
    blk_rel = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [IN_WIDTH-1:0] base;
    int                  budget;

    apply_reset();

    // Four-word little-endian block.
    for (int i = 0; i < 4; i++) begin
      base = 32'h03020100 + 32'(i) * 32'h04040404;
      send_word(base, 1'b0);
    end
    check("t1_wen",  D_WIDTH'(w_en),   D_WIDTH'(1));
    check("t1_addr", D_WIDTH'(w_addr), D_WIDTH'(0));
    check("t1_data", w_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    check("t1_last", D_WIDTH'(w_last), D_WIDTH'(0));
    check("t1_fill", D_WIDTH'(fill),   D_WIDTH'(1));

    // Short final block zero-pads, next word restarts at lane 0.
    send_word(32'hAAAAAAAA, 1'b0);
    send_word(32'hBBBBBBBB, 1'b1);
    check("t2_data", w_data, 128'h00000000_00000000_BBBBBBBB_AAAAAAAA);
    check("t2_last", D_WIDTH'(w_last), D_WIDTH'(1));
    check("t2_addr", D_WIDTH'(w_addr), D_WIDTH'(1));
    send_word(32'h11111111, 1'b1);
    check("t2_lane0", w_data, 128'h00000000_00000000_00000000_11111111);
    check("t2_fill", D_WIDTH'(fill), D_WIDTH'(3));

    // Commit and release on the same edge, then release below zero.
    blk_rel = 1'b1;
    send_word(32'h55555555, 1'b1);
    blk_rel = 1'b0;
    check("t4_same_edge_fill", D_WIDTH'(fill), D_WIDTH'(3));
    repeat (3) pulse_rel();
    check("t4_drained", D_WIDTH'(fill), D_WIDTH'(0));
    pulse_rel();
    check("t4_underflow_fill", D_WIDTH'(fill), D_WIDTH'(0));
    check("t4_err_set", D_WIDTH'(err), D_WIDTH'(1));
    repeat (5) @(posedge clk);
    #1;
    check("t4_err_sticky", D_WIDTH'(err), D_WIDTH'(1));

    // Async reset in the middle of a block discards the partial lanes.
    send_word(32'hDEADBEEF, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    apply_reset();
    for (int i = 0; i < 4; i++) send_word(32'h10000000 + 32'(i), 1'b0);
    check("t5_addr", D_WIDTH'(w_addr), D_WIDTH'(0));
    check("t5_data", w_data, 128'h10000003_10000002_10000001_10000000);

    // Fill all slots, hold off, release one and wrap the address.
    apply_reset();
    for (int b = 0; b < DEPTH; b++) begin
      for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
      check("t3_addr", D_WIDTH'(w_addr), D_WIDTH'(b));
    end
    check("t3_fill_full", D_WIDTH'(fill),     D_WIDTH'(DEPTH));
    check("t3_full",      D_WIDTH'(full),     D_WIDTH'(1));
    check("t3_ready_low", D_WIDTH'(in_ready), D_WIDTH'(0));
    in_valid = 1'b1;
    in_data  = 32'h99999999;
    in_last  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t3_no_accept", D_WIDTH'(fill), D_WIDTH'(DEPTH));
    pulse_rel();
    check("t3_ready_after_rel", D_WIDTH'(in_ready), D_WIDTH'(1));
    for (int i = 0; i < 4; i++) send_word($urandom, 1'b0);
    check("t3_wrap_addr", D_WIDTH'(w_addr), D_WIDTH'(0));

    // Random traffic with a concurrent random consumer.
    apply_reset();
    rand_done = 1'b0;
    fork
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          blk_rel = (m_fill > 0) && ($urandom_range(0, 7) == 0);
        end
        blk_rel = 1'b0;
      end
    join_none
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_word($urandom, $urandom_range(0, 4) == 0);
    end
    rand_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    budget = 100;
    while (m_fill > 0 && budget > 0) begin
      pulse_rel();
      budget--;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rand_drained",  D_WIDTH'(fill),         D_WIDTH'(0));
    check("rand_sb_empty", D_WIDTH'(sb_q.size()),  D_WIDTH'(0));
    check("rand_max_fill", D_WIDTH'(max_fill <= DEPTH), D_WIDTH'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_block_packer.md
# ram_block_packer

Write-side feeder for the 128-bit dual-port block RAM in the ChaCha20-Poly1305 datapath. It accepts a stream of 32-bit words over a valid/ready handshake, packs four words little-endian into one 128-bit block, and issues one registered RAM write per block at sequential, wrapping addresses. It tracks RAM occupancy against release pulses from the read-side consumer and back-pressures the source when all slots are held. A short final block is zero-padded.

## Interface
- D_WIDTH, 128, RAM word width; must equal 4*IN_WIDTH
- IN_WIDTH, 32, input word width
- A_WIDTH, 3, RAM address width; DEPTH = 2**A_WIDTH slots
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  source word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  IN_WIDTH  source word
- in_last  in  1  word is the final word of the message
- w_en  out  1  RAM write enable, one-cycle pulse per block
- w_addr  out  A_WIDTH  RAM write address
- w_data  out  D_WIDTH  packed block
- w_last  out  1  high with w_en when the block holds the in_last word
- blk_rel  in  1  consumer pulse: one RAM slot has been read and freed
- fill  out  A_WIDTH+1  number of committed, unreleased blocks
- full  out  1  fill == DEPTH
- empty  out  1  fill == 0
- err  out  1  sticky: blk_rel seen while fill == 0

## Operation
- Accept = in_valid & in_ready. in_ready = ~full, independent of in_valid and lane position; held 0 while rst is high.
- lane counter (0..3) selects the slice: word at lane k goes to bits [32k+31:32k] of the assembly register.
- Completing word = accepted word with lane == 3 or in_last == 1. It commits a block: lanes above the current one are zero, lane resets to 0, fill reserves one slot.
- Non-completing accept: store the slice, lane += 1, no write.
- fill update per cycle: +1 on commit, -1 on blk_rel when fill > 0, unchanged on both together. blk_rel at fill == 0 leaves fill at 0 and sets err (cleared only by rst).
- The commit cannot overflow: in_ready is 0 when full, so a commit only happens with fill < DEPTH.
- w_addr advances by 1 after each w_en pulse, modulo DEPTH (DEPTH-1 wraps to 0).
- The block never reads the RAM. The consumer reads slots in the same wrapping order and pulses blk_rel once per slot consumed.

## Timing
- Reset values: in_ready 0 (while rst), w_en 0, w_addr 0, w_data 0, w_last 0, fill 0, full 0, empty 1, err 0, lane 0.
- Write latency: a completing word accepted at edge t gives w_en = 1 with the packed w_data, w_last and the current w_addr for exactly the cycle after edge t.
- w_data holds its value after the pulse. Only w_en qualifies it.
- fill, full and empty update at the same edge as the commit, so the next word sees in_ready = 0 if that commit filled the RAM.
- blk_rel at edge t while full: in_ready = 1 in the cycle after t.
- Back-to-back: a full 4-word block every 4 cycles, and a 1-word in_last block every cycle, are sustained with no bubbles while fill < DEPTH.
- Reset mid-block: the partial lanes are discarded and no write is issued. w_addr returns to 0.

## Test plan
- Words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles -> one w_en pulse after the 4th accept, w_addr = 0, w_data = 0x0F0E0D0C_0B0A0908_07060504_03020100, w_last 0, fill = 1.
- Words 0xAAAAAAAA, 0xBBBBBBBB with in_last on the second -> w_data = 0x00000000_00000000_BBBBBBBB_AAAAAAAA, w_last 1, lane back to 0, next word lands in lane 0.
- Send 8 full blocks with no blk_rel -> w_addr 0..7, fill = 8, full 1, in_ready 0. Hold in_valid high -> no accept. Pulse blk_rel once -> in_ready 1 the next cycle, and the 9th block is written at w_addr = 0 (wrap).
- With fill = 3, a commit and blk_rel on the same edge -> fill stays 3. blk_rel at fill = 0 -> fill stays 0 and err = 1, remaining set until rst.
- Accept 2 words, then assert rst asynchronously between edges -> all outputs at reset values immediately. After release, 4 new words produce w_addr = 0 with no stale lanes.
- Random in_valid and blk_rel over 1000 words -> the scoreboard matches each block's content and address order, fill never exceeds 8, and no accept happens while full.
